// File: rtl/simd_issue_unit.sv
// Single-issue SIMD front end: reads a vector register pair, hands operands to an
// external combinational ALU, and writes the lane-masked result back three cycles later.
module simd_issue_unit #(
  parameter int unsigned REGS = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [1:0]      instr_op,
  input  logic [3:0]      instr_mask,
  input  logic [IDXW-1:0] instr_ra,
  input  logic [IDXW-1:0] instr_rb,
  input  logic [IDXW-1:0] instr_rd,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [31:0]     wr_data,
  input  logic [IDXW-1:0] rd_idx,
  output logic [31:0]     rd_data,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [3:0]      alu_mask,
  output logic [1:0]      alu_op,
  input  logic [31:0]     alu_result,
  output logic            done,
  output logic [IDXW-1:0] done_rd,
  output logic [31:0]     done_data,
  output logic            busy
);

  localparam int unsigned DW    = 32;
  localparam int unsigned LANES = 4;
  localparam int unsigned LW    = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [DW-1:0]   regs [REGS];
  logic [DW-1:0]   res_q;
  logic [IDXW-1:0] rd_q;
  logic [DW-1:0]   merged;
  logic            handshake;
  logic            wb_en;

  assign instr_ready = (state_q == S_IDLE) && rst_n;
  assign handshake   = instr_valid && instr_ready;
  assign wb_en       = (state_q == S_WB);
  assign busy        = (state_q != S_IDLE);
  assign rd_data     = regs[rd_idx];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (handshake) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane merge: enabled lanes take the result, the rest keep the current destination value
  always_comb begin
    merged = regs[rd_q];
    for (int n = 0; n < LANES; n++) begin
      if (alu_mask[n]) merged[n*LW +: LW] = res_q[n*LW +: LW];
    end
  end

  // Operand latch, result capture and completion reporting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_mask  <= '0;
      alu_op    <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      done      <= 1'b0;
      done_rd   <= '0;
      done_data <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (handshake) begin
            alu_a    <= regs[instr_ra];
            alu_b    <= regs[instr_rb];
            alu_mask <= instr_mask;
            alu_op   <= instr_op;
            rd_q     <= instr_rd;
          end
        end
        S_EXEC: res_q <= alu_result;
        S_WB: begin
          done      <= 1'b1;
          done_rd   <= rd_q;
          done_data <= merged;
        end
        default: ;
      endcase
    end
  end

  // Register file; writeback beats a host write to the same register on the WB edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else begin
      if (wr_en && !(wb_en && (wr_idx == rd_q))) regs[wr_idx] <= wr_data;
      if (wb_en) regs[rd_q] <= merged;
    end
  end

endmodule

// File: tb/tb_simd_issue_unit.sv
// Randomised self-checking bench for simd_issue_unit; a lane-wise ALU model closes the
// alu_* loop and a register-array reference model predicts every writeback.
module tb_simd_issue_unit;

  localparam int unsigned IDXW = 2;
  localparam int unsigned REGS = 4;

  logic            clk;
  logic            rst_n;
  logic            instr_valid;
  logic            instr_ready;
  logic [1:0]      instr_op;
  logic [3:0]      instr_mask;
  logic [IDXW-1:0] instr_ra, instr_rb, instr_rd;
  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [31:0]     wr_data;
  logic [IDXW-1:0] rd_idx;
  logic [31:0]     rd_data;
  logic [31:0]     alu_a, alu_b, alu_result;
  logic [3:0]      alu_mask;
  logic [1:0]      alu_op;
  logic            done;
  logic [IDXW-1:0] done_rd;
  logic [31:0]     done_data;
  logic            busy;

  int n_checks;
  int n_fail;
  logic [31:0] mdl [REGS];

  simd_issue_unit #(.REGS(REGS), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_mask(instr_mask),
    .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_rd(instr_rd),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mask(alu_mask), .alu_op(alu_op),
    .alu_result(alu_result),
    .done(done), .done_rd(done_rd), .done_data(done_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane-wise 8-bit ALU: plain integer arithmetic reduced modulo 256
  function automatic logic [31:0] lane_alu(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    int x, y, z;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      x = int'(a[l*8 +: 8]);
      y = int'(b[l*8 +: 8]);
      case (op)
        2'd0:    z = (x + y) % 256;
        2'd1:    z = (x * y) % 256;
        2'd2:    z = x & y;
        default: z = x | y;
      endcase
      r[l*8 +: 8] = 8'(z);
    end
    return r;
  endfunction

  always_comb alu_result = lane_alu(alu_op, alu_a, alu_b);

  function automatic logic [31:0] predict(input logic [1:0] op, input logic [3:0] mask,
                                          input logic [1:0] ra, input logic [1:0] rb,
                                          input logic [1:0] rd);
    logic [31:0] full, r;
    full = lane_alu(op, mdl[ra], mdl[rb]);
    r = mdl[rd];
    for (int l = 0; l < 4; l++) if (mask[l]) r[l*8 +: 8] = full[l*8 +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] idx, input logic [31:0] d);
    wr_en = 1'b1; wr_idx = idx; wr_data = d;
    tick();
    wr_en = 1'b0;
    mdl[idx] = d;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [3:0] mask, input logic [1:0] ra,
                           input logic [1:0] rb, input logic [1:0] rd);
    instr_op = op; instr_mask = mask; instr_ra = ra; instr_rb = rb; instr_rd = rd;
  endtask

  // Issues one instruction; lat = edges from the handshake to the edge that samples done high
  task automatic do_instr(input logic [1:0] op, input logic [3:0] mask, input logic [1:0] ra,
                          input logic [1:0] rb, input logic [1:0] rd, output int lat,
                          output logic [31:0] data, output logic [1:0] drd,
                          output int alu_bad, output logic [31:0] exp_v);
    logic [31:0] ea, eb;
    ea = mdl[ra]; eb = mdl[rb];
    exp_v = predict(op, mask, ra, rb, rd);
    set_instr(op, mask, ra, rb, rd);
    instr_valid = 1'b1;
    for (int k = 0; k < 10 && !instr_ready; k++) tick();
    tick();
    instr_valid = 1'b0;
    lat = -1; alu_bad = 0; data = 'x; drd = 'x;
    for (int k = 0; k < 8; k++) begin
      if (k < 3 && (alu_a !== ea || alu_b !== eb || alu_mask !== mask || alu_op !== op))
        alu_bad++;
      if (done === 1'b1) begin
        lat = k + 1; data = done_data; drd = done_rd;
        break;
      end
      tick();
    end
    mdl[rd] = exp_v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; wr_en = 1'b0; rd_idx = '0;
    set_instr(2'd0, 4'd0, 2'd0, 2'd0, 2'd0);
    wr_idx = '0; wr_data = '0;
    tick(); tick();
    for (int i = 0; i < REGS; i++) mdl[i] = '0;
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", instr_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0 || done_rd !== 2'd0 || done_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_done: got %b/%0d/%h want 0/0/0", done, done_rd, done_data); end
    n_checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_mask !== 4'd0 || alu_op !== 2'd0) begin
      n_fail++; $display("FAIL reset_alu: got %h %h %h %h want zeros", alu_a, alu_b, alu_mask, alu_op); end
    for (int i = 0; i < REGS; i++) begin
      rd_idx = 2'(i); #1;
      n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 0", i, rd_data); end
    end
    rst_n = 1'b1; #1;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", instr_ready); end
  endtask

  task automatic test_add();
    int lat, ab; logic [31:0] d, e; logic [1:0] r;
    host_write(2'd0, 32'h04030201);
    host_write(2'd1, 32'h10203040);
    do_instr(2'd0, 4'b1111, 2'd0, 2'd1, 2'd2, lat, d, r, ab, e);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d want 3", lat); end
    n_checks++; if (d !== 32'h14233241) begin n_fail++; $display("FAIL add_data: got %h want 14233241", d); end
    n_checks++; if (r !== 2'd2) begin n_fail++; $display("FAIL add_rd: got %0d want 2", r); end
    n_checks++; if (ab !== 0) begin n_fail++; $display("FAIL add_alu_stable: got %0d bad samples want 0", ab); end
    n_checks++; if (busy !== 1'b0 || instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_idle_after_wb: got busy=%b ready=%b want 0/1", busy, instr_ready); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", done); end
    rd_idx = 2'd2; #1;
    n_checks++; if (rd_data !== 32'h14233241) begin n_fail++; $display("FAIL add_reg: got %h want 14233241", rd_data); end
  endtask

  task automatic test_mul_wrap();
    int lat, ab; logic [31:0] d, e; logic [1:0] r;
    host_write(2'd3, 32'hAABBCCDD);
    do_instr(2'd1, 4'b0101, 2'd0, 2'd1, 2'd3, lat, d, r, ab, e);
    n_checks++; if (d !== 32'hAA60CC40) begin n_fail++; $display("FAIL mul_data: got %h want AA60CC40", d); end
    rd_idx = 2'd3; #1;
    n_checks++; if (rd_data !== 32'hAA60CC40) begin n_fail++; $display("FAIL mul_reg: got %h want AA60CC40", rd_data); end
    host_write(2'd0, 32'hFFFFFFFF);
    host_write(2'd1, 32'h02020202);
    do_instr(2'd0, 4'b1111, 2'd0, 2'd1, 2'd2, lat, d, r, ab, e);
    n_checks++; if (d !== 32'h01010101) begin n_fail++; $display("FAIL wrap_data: got %h want 01010101", d); end
  endtask

  task automatic test_mask_zero();
    int lat, ab; logic [31:0] d, e; logic [1:0] r;
    host_write(2'd2, 32'h12345678);
    do_instr(2'd3, 4'b0000, 2'd0, 2'd1, 2'd2, lat, d, r, ab, e);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL mask0_latency: got %0d want 3", lat); end
    n_checks++; if (d !== 32'h12345678) begin n_fail++; $display("FAIL mask0_data: got %h want 12345678", d); end
    tick(); tick();
    n_checks++; if (done_rd !== 2'd2 || done_data !== 32'h12345678) begin
      n_fail++; $display("FAIL mask0_hold: got %0d/%h want 2/12345678", done_rd, done_data); end
    rd_idx = 2'd2; #1;
    n_checks++; if (rd_data !== 32'h12345678) begin n_fail++; $display("FAIL mask0_reg: got %h want 12345678", rd_data); end
  endtask

  task automatic test_alias();
    int lat, ab; logic [31:0] d, e; logic [1:0] r;
    host_write(2'd1, 32'h03050709);
    do_instr(2'd1, 4'b1111, 2'd1, 2'd1, 2'd1, lat, d, r, ab, e);
    n_checks++; if (d !== 32'h09193151) begin n_fail++; $display("FAIL alias_data: got %h want 09193151", d); end
  endtask

  task automatic test_back_to_back();
    int low, lat;
    logic [31:0] e1, e2;
    host_write(2'd0, 32'h01020304);
    host_write(2'd1, 32'h01010101);
    e1 = predict(2'd0, 4'hF, 2'd0, 2'd1, 2'd2);
    mdl[2] = e1;
    e2 = predict(2'd0, 4'hF, 2'd2, 2'd1, 2'd3);
    mdl[3] = e2;
    set_instr(2'd0, 4'hF, 2'd0, 2'd1, 2'd2);
    instr_valid = 1'b1;
    tick();
    set_instr(2'd0, 4'hF, 2'd2, 2'd1, 2'd3);
    low = 0;
    for (int k = 0; k < 6 && !instr_ready; k++) begin low++; tick(); end
    n_checks++; if (low !== 2) begin n_fail++; $display("FAIL b2b_ready_gap: got %0d want 2", low); end
    n_checks++; if (done !== 1'b1 || done_data !== 32'h02030405) begin
      n_fail++; $display("FAIL b2b_first: got %b/%h want 1/02030405", done, done_data); end
    tick();
    instr_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) begin lat = k + 1; break; end
      tick();
    end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL b2b_latency: got %0d want 3", lat); end
    n_checks++; if (done_data !== e2 || e2 !== 32'h03040506) begin
      n_fail++; $display("FAIL b2b_second: got %h want 03040506", done_data); end
  endtask

  task automatic test_host_writes();
    logic [31:0] e;
    host_write(2'd0, 32'h01010101);
    host_write(2'd1, 32'h11223344);
    host_write(2'd3, 32'hA0B0C0D0);
    set_instr(2'd3, 4'b0011, 2'd0, 2'd1, 2'd3);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    wr_en = 1'b1; wr_idx = 2'd3; wr_data = 32'h55667788;
    tick();
    wr_en = 1'b0;
    mdl[3] = 32'h55667788;
    e = 32'h55663345;
    mdl[3] = e;
    tick();
    n_checks++; if (done !== 1'b1 || done_data !== e) begin
      n_fail++; $display("FAIL exec_hostwr: got %b/%h want 1/%h", done, done_data, e); end
    e = predict(2'd0, 4'hF, 2'd0, 2'd1, 2'd2);
    set_instr(2'd0, 4'hF, 2'd0, 2'd1, 2'd2);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    wr_en = 1'b1; wr_idx = 2'd2; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    mdl[2] = e;
    rd_idx = 2'd2; #1;
    n_checks++; if (rd_data !== 32'h12233445) begin
      n_fail++; $display("FAIL wb_collision: got %h want 12233445", rd_data); end
  endtask

  task automatic test_reset_abort();
    int seen;
    for (int v = 0; v < 2; v++) begin
      host_write(2'd0, 32'h01010101);
      host_write(2'd1, 32'h02020202);
      set_instr(2'd0, 4'hF, 2'd0, 2'd1, 2'd2);
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      if (v == 1) tick();
      rst_n = 1'b0;
      tick();
      for (int i = 0; i < REGS; i++) mdl[i] = '0;
      seen = (done === 1'b1) ? 1 : 0;
      n_checks++; if (busy !== 1'b0 || instr_ready !== 1'b0 || alu_a !== 32'd0 || done_data !== 32'd0) begin
        n_fail++; $display("FAIL abort%0d_outputs: got busy=%b ready=%b alu_a=%h dd=%h want 0", v, busy, instr_ready, alu_a, done_data); end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin tick(); if (done === 1'b1) seen++; end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort%0d_done: got %0d pulses want 0", v, seen); end
      rd_idx = 2'd2; #1;
      n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL abort%0d_reg: got %h want 0", v, rd_data); end
    end
  endtask

  task automatic test_random();
    int lat, ab, errs;
    logic [31:0] d, e;
    logic [1:0] r, op, ra, rb, rd;
    logic [3:0] mask;
    errs = 0;
    for (int i = 0; i < REGS; i++) host_write(2'(i), $urandom);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) host_write(2'($urandom_range(0, 3)), $urandom);
      op = 2'($urandom_range(0, 3)); mask = 4'($urandom_range(0, 15));
      ra = 2'($urandom_range(0, 3)); rb = 2'($urandom_range(0, 3)); rd = 2'($urandom_range(0, 3));
      do_instr(op, mask, ra, rb, rd, lat, d, r, ab, e);
      n_checks++; if (lat !== 3 || d !== e || r !== rd || ab !== 0) begin
        n_fail++; $display("FAIL rand%0d: got lat=%0d data=%h rd=%0d alu_bad=%0d want 3/%h/%0d/0", it, lat, d, r, ab, e, rd); end
    end
    for (int i = 0; i < REGS; i++) begin
      rd_idx = 2'(i); #1;
      n_checks++; if (rd_data !== mdl[i]) begin n_fail++; $display("FAIL rand_reg%0d: got %h want %h", i, rd_data, mdl[i]); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_mul_wrap();
    test_mask_zero();
    test_alias();
    test_back_to_back();
    test_host_writes();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simd_issue_unit.md
SIMD_ISSUE_UNIT -- requirements
Module: simd_issue_unit

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter: REGS, default 4, number of 32-bit vector registers (4 lanes x 8 bits each).
REQ-003 Parameter: IDXW, default 2, register index width; REGS SHALL equal 2**IDXW.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 instr_valid  in  1  instruction offered.
REQ-007 instr_ready  out  1  instruction accepted when instr_valid and instr_ready are both high at a rising edge.
REQ-008 instr_op  in  2  ALU opcode (00 ADD, 01 MUL, 10 AND, 11 OR).
REQ-009 instr_mask  in  4  lane enable mask; bit n selects lane n, bits [8n+7:8n].
REQ-010 instr_ra, instr_rb, instr_rd  in  IDXW each  source A, source B, destination register.
REQ-011 wr_en, wr_idx, wr_data  in  1/IDXW/32  host register preload.
REQ-012 rd_idx  in  IDXW; rd_data  out  32  combinational host readback of reg[rd_idx].
REQ-013 alu_a, alu_b  out  32; alu_mask  out  4; alu_op  out  2  registered operands to the combinational simd_alu.
REQ-014 alu_result  in  32  combinational ALU result.
REQ-015 done  out  1  one-cycle completion pulse; done_rd  out  IDXW; done_data  out  32  merged value written.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, WB; instr_ready SHALL equal (state==IDLE) and rst_n.
REQ-018 IDLE: on handshake, latch alu_a=reg[ra], alu_b=reg[rb], alu_mask, alu_op, and rd; go to EXEC. Without a handshake, remain in IDLE.
REQ-019 EXEC: capture alu_result into an internal result register; go to WB.
REQ-020 WB: write reg[rd] lane-wise, taking result lane n if alu_mask[n]=1, else keeping the old reg[rd] lane n; set done=1, done_rd=rd, done_data=merged value; go to IDLE.
REQ-021 done SHALL be high for exactly one cycle, the cycle after the WB edge; done_rd and done_data SHALL hold their values until the next done.
REQ-022 Latency: handshake at edge E0 SHALL give done high after edge E0+3 cycles. The next handshake SHALL be possible at that same edge E0+3, giving one instruction per 3 cycles maximum.
REQ-023 alu_* outputs SHALL remain stable from the IDLE-exit edge through the WB edge.
REQ-024 Lane arithmetic SHALL be the ALU's 8-bit wrap-around; the block SHALL apply no saturation or extension.
REQ-025 mask=0000 SHALL still traverse all states and pulse done, with reg[rd] unchanged and done_data equal to the old reg[rd].
REQ-026 Operand read SHALL see register values before any write on the same edge; there is no forwarding within the same edge.
REQ-027 Back-to-back instructions SHALL see the previous writeback, because the WB write completes before the next IDLE read edge.
REQ-028 wr_en SHALL be honoured in every state; if wr_en targets rd on the WB edge, the instruction writeback SHALL win and the host write is dropped.
REQ-029 ra=rb=rd aliasing SHALL be legal; operands SHALL be the pre-instruction value.

Reset
REQ-030 While rst_n=0 at an edge: state=IDLE, all registers=0, alu_a=alu_b=0, alu_mask=0, alu_op=0, done=0, done_rd=0, done_data=0, busy=0, instr_ready=0.
REQ-031 Reset asserted in EXEC or WB SHALL abort the instruction: no register write and no done pulse.
REQ-032 The first handshake SHALL be possible at the first edge with rst_n=1.

Verification (bench wires alu_* to simd_alu)
REQ-033 Preload r0=0x04030201, r1=0x10203040; ADD mask 1111 ra=0 rb=1 rd=2 -> done 3 cycles after the handshake, done_data=r2=0x14233241.
REQ-034 r3=0xAABBCCDD; MUL mask 0101 ra=0 rb=1 rd=3 -> r3=0xAA60CC40; r0=0xFFFFFFFF r1=0x02020202 ADD -> lanes wrap to 0x01010101.
REQ-035 mask 0000 OR into r2=0x12345678 -> done pulses, r2 remains 0x12345678, done_data=0x12345678.
REQ-036 instr_valid held high for two instructions, where the second has ra equal to the first's rd -> instr_ready low for 2 cycles between handshakes, and the second uses the updated value.
REQ-037 rst_n low in EXEC -> no done pulse, rd unchanged (0 after reset), all outputs at reset values; wr_en to rd on the WB edge -> the instruction result persists.
